// File: rtl/memreg_loader.sv
// Loads a bank of memreg registers from NVM trim words at reset and on request.
// It reads one word per register, then pulses that register's write enable for one cycle.
module memreg_loader #(
  parameter int                NUM_REGS  = 8,
  parameter int                REGSIZE   = 8,
  parameter int                MEM_AW    = 8,
  parameter logic [MEM_AW-1:0] BASE_ADDR = 8'h00,
  parameter int                TIMEOUT   = 15,
  parameter bit                AUTOLOAD  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_mem_rd_req,
  output logic [MEM_AW-1:0]   o_mem_addr,
  input  logic                i_mem_rd_ack,
  input  logic [REGSIZE-1:0]  i_mem_rd_data,
  output logic [REGSIZE-1:0]  o_mem_data,
  output logic [NUM_REGS-1:0] o_mem_wr_en,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int IDX_W = $clog2(NUM_REGS);
  // The counter only has to reach TIMEOUT-1; the next miss ends the wait.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, REQ, WRITE, DONE, ERR} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [REGSIZE-1:0] data_reg, data_next;
  logic               autoload_reg, autoload_next;
  logic               go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      cnt_reg      <= '0;
      data_reg     <= '0;
      autoload_reg <= AUTOLOAD;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      cnt_reg      <= cnt_next;
      data_reg     <= data_next;
      autoload_reg <= autoload_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    cnt_next      = cnt_reg;
    data_next     = data_reg;
    autoload_next = autoload_reg;
    go            = 1'b0;
    case (state_reg)
      IDLE:      go = i_start | autoload_reg;
      DONE, ERR: go = i_start;
      REQ: begin
        if (i_mem_rd_ack) begin
          data_next  = i_mem_rd_data;
          state_next = WRITE;
        end else if (TIMEOUT != 0) begin
          if (cnt_reg == CNT_LAST) state_next = ERR;
          else                     cnt_next   = cnt_reg + CNT_W'(1);
        end
      end
      WRITE: begin
        if (idx_reg == IDX_LAST) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          cnt_next   = '0;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
    // Starting from any idle-type state restarts the whole bank from register 0.
    if (go) begin
      state_next    = REQ;
      idx_next      = '0;
      cnt_next      = '0;
      autoload_next = 1'b0;
    end
  end

  assign o_mem_rd_req = (state_reg == REQ);
  assign o_busy       = (state_reg == REQ) || (state_reg == WRITE);
  assign o_done       = (state_reg == DONE);
  assign o_err        = (state_reg == ERR);
  assign o_mem_data   = data_reg;
  assign o_mem_addr   = BASE_ADDR + MEM_AW'(idx_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_en
      assign o_mem_wr_en[gi] = (state_reg == WRITE) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_memreg_loader.sv
// Directed bench for memreg_loader: table of load scenarios plus reset, wrap and collision sequences.
module tb_memreg_loader;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       req, ack, busy, done, err;
  logic [7:0] addr, rd_data, mem_data, wr_en;
  logic       w_req, w_busy, w_done, w_err;
  logic [7:0] w_addr, w_data, w_wr_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memreg_loader #(.NUM_REGS(8), .REGSIZE(8), .MEM_AW(8), .BASE_ADDR(8'h10),
                  .TIMEOUT(15), .AUTOLOAD(1'b1)) dut (
    .clk(clk), .rst(rst), .i_start(start),
    .o_mem_rd_req(req), .o_mem_addr(addr), .i_mem_rd_ack(ack), .i_mem_rd_data(rd_data),
    .o_mem_data(mem_data), .o_mem_wr_en(wr_en), .o_busy(busy), .o_done(done), .o_err(err)
  );

  // Second loader only used to observe address wrap-around.
  memreg_loader #(.NUM_REGS(8), .REGSIZE(8), .MEM_AW(8), .BASE_ADDR(8'hFE),
                  .TIMEOUT(15), .AUTOLOAD(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .i_start(start),
    .o_mem_rd_req(w_req), .o_mem_addr(w_addr), .i_mem_rd_ack(w_req), .i_mem_rd_data(w_addr),
    .o_mem_data(w_data), .o_mem_wr_en(w_wr_en), .o_busy(w_busy), .o_done(w_done), .o_err(w_err)
  );

  // Memory model: word at address a is a+0x90, so 0x10+k holds 0xA0+k.
  int ack_delay = 0;
  int hold_idx  = -1;
  int wait_cnt  = 0;
  assign ack     = req && (wait_cnt >= ack_delay) &&
                   !(hold_idx >= 0 && addr == 8'(8'h10 + hold_idx));
  assign rd_data = addr + 8'h90;

  always @(posedge clk) begin
    if (req && !ack) wait_cnt <= wait_cnt + 1;
    else             wait_cnt <= 0;
  end

  // Register bank model; a regbank write beats the loader write.
  logic       col_en = 1'b0;
  logic [7:0] bank [8];
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (col_en && k == 2 && wr_en[2]) bank[k] <= 8'h55;
      else if (wr_en[k])                bank[k] <= mem_data;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int         wcount [8];
  logic       prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic       wrap_rec = 1'b1;
  logic [7:0] wrap_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en != 8'h00) begin
        check("wr_en_onehot", int'($onehot(wr_en)), 1);
        for (int k = 0; k < 8; k++) begin
          if (wr_en[k]) begin
            wcount[k]++;
            check($sformatf("wr_data_%0d", k), int'(mem_data), int'(8'(8'hA0 + k)));
          end
        end
      end
      if (req && prev_req) check("addr_stable", int'(addr), int'(prev_addr));
      if (w_req && wrap_rec) wrap_q.push_back(w_addr);
    end
    prev_req  = req && !rst;
    prev_addr = addr;
  end

  task automatic clear_counts();
    for (int k = 0; k < 8; k++) wcount[k] = 0;
  endtask

  // Starts a load (start pulse or reset release) and counts edges until done/err.
  task automatic run_load(input bit use_start, input int poke, output int edges);
    edges = 300;
    @(negedge clk);
    if (use_start) start = 1'b1;
    else           rst   = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      start = (n == poke);
      if (done || err) begin
        edges = n;
        break;
      end
    end
    start = 1'b0;
    $display("load: edges=%0d done=%0b err=%0b busy=%0b", edges, done, err, busy);
  endtask

  typedef struct {
    int         delay;
    int         hold;
    int         poke;
    int         exp_edges;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] wexp [8];
  int         edges;
  bit         found;

  initial begin
    vecs[0] = '{0, -1, 0, 17, 1'b1, 1'b0, 8'hFF};
    vecs[1] = '{3, -1, 0, 41, 1'b1, 1'b0, 8'hFF};
    vecs[2] = '{0,  5, 0, 26, 1'b0, 1'b1, 8'h1F};
    vecs[3] = '{0, -1, 0, 17, 1'b1, 1'b0, 8'hFF};
    vecs[4] = '{1,  2, 0, 22, 1'b0, 1'b1, 8'h03};
    vecs[5] = '{0, -1, 5, 17, 1'b1, 1'b0, 8'hFF};
    vecs[6] = '{2, -1, 0, 33, 1'b1, 1'b0, 8'hFF};
    wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", int'(addr), 8'h10);
    check("rst_wrap_addr", int'(w_addr), 8'hFE);
    check("rst_req", int'(req), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_flags", int'({busy, done, err}), 0);
    check("rst_data", int'(mem_data), 0);

    // Autoload after reset release with immediate ack.
    clear_counts();
    run_load(1'b0, 0, edges);
    check("auto_edges", edges, 17);
    check("auto_done", int'(done), 1);
    check("auto_err", int'(err), 0);
    for (int k = 0; k < 8; k++) check($sformatf("auto_wcount_%0d", k), wcount[k], 1);
    wrap_rec = 1'b0;
    check("wrap_count", wrap_q.size(), 8);
    for (int k = 0; k < 8 && k < wrap_q.size(); k++)
      check($sformatf("wrap_addr_%0d", k), int'(wrap_q[k]), int'(wexp[k]));

    for (int i = 0; i < 7; i++) begin
      ack_delay = vecs[i].delay;
      hold_idx  = vecs[i].hold;
      clear_counts();
      run_load(1'b1, vecs[i].poke, edges);
      check($sformatf("v%0d_edges", i), edges, vecs[i].exp_edges);
      check($sformatf("v%0d_done", i), int'(done), int'(vecs[i].exp_done));
      check($sformatf("v%0d_err", i), int'(err), int'(vecs[i].exp_err));
      check($sformatf("v%0d_busy", i), int'(busy), 0);
      for (int k = 0; k < 8; k++)
        check($sformatf("v%0d_wcount_%0d", i, k), wcount[k], int'(vecs[i].exp_mask[k]));
    end
    ack_delay = 0;
    hold_idx  = -1;

    // Asynchronous reset in the middle of register 3's write cycle.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (wr_en[3]) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("midrst_reached_w3", int'(found), 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_wr_en", int'(wr_en), 0);
    check("midrst_req", int'(req), 0);
    check("midrst_flags", int'({busy, done, err}), 0);
    check("midrst_addr", int'(addr), 8'h10);
    check("midrst_data", int'(mem_data), 0);
    $display("reset mid-load: wr_en=0x%0h busy=%0b", wr_en, busy);
    clear_counts();
    run_load(1'b0, 0, edges);
    check("midrst_edges", edges, 17);
    check("midrst_done", int'(done), 1);
    for (int k = 0; k < 8; k++) check($sformatf("midrst_wcount_%0d", k), wcount[k], 1);

    // Regbank write colliding with the loader write of register 2.
    col_en = 1'b1;
    clear_counts();
    run_load(1'b1, 0, edges);
    col_en = 1'b0;
    @(negedge clk);
    check("col_edges", edges, 17);
    check("col_done", int'(done), 1);
    check("col_bank2", int'(bank[2]), 8'h55);
    check("col_bank1", int'(bank[1]), 8'hA1);
    check("col_bank3", int'(bank[3]), 8'hA3);
    $display("collision: bank2=0x%0h done=%0b", bank[2], done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
